sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO; successor to the team's fixed 8-bit dual-clock FIFO for same-domain buffering.
- Generalised in data width and depth.
- Adds fill count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses.
- Sits between a producer and a consumer in one clock domain, e.g. in front of a serialiser or behind a packet parser.

---
 rtl/sync_fifo_pkg.sv | 30 +++
 rtl/sync_fifo_param_if.sv | 39 +++
 rtl/sync_fifo_ram.sv | 28 ++
 rtl/sync_fifo_param.sv | 97 +++++++++
 tb/tb_sync_fifo_param.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared helpers for the parametrised single-clock FIFO:
//   addr_width() - storage address width for a given depth
//   ptr_width()  - read/write pointer and fill-count width (one extra MSB
//                  so that a full FIFO and an empty FIFO differ)
//   params_ok()  - legality check for the FIFO parameter set
package sync_fifo_pkg;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return addr_width(depth) + 1;
    endfunction

    // DEPTH must be a power of two so that pointer rollover is plain binary.
    function automatic bit params_ok(input int width, input int depth,
                                     input int af_thresh, input int ae_thresh);
        bit ok;
        ok = 1'b1;
        if (width < 1) ok = 1'b0;
        if (depth < 2) ok = 1'b0;
        if ((depth & (depth - 1)) != 0) ok = 1'b0;
        if (af_thresh < 1 || af_thresh > depth) ok = 1'b0;
        if (ae_thresh < 0 || ae_thresh > depth - 1) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if
// Producer/consumer handshake bundle for sync_fifo_param.
//   write_en, data_in       : producer write request and data
//   read_en, out            : consumer read request and read data
//   mem_full, mem_empty     : occupancy flags
//   almost_full/_empty      : threshold flags
//   fill_count              : number of stored entries (0..DEPTH)
//   overflow, underflow     : one-cycle pulses for rejected requests
// Modports: master = producer/consumer side, slave = FIFO side.
interface sync_fifo_param_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic                          write_en;
    logic                          read_en;
    logic [WIDTH-1:0]              data_in;
    logic [WIDTH-1:0]              out;
    logic                          mem_full;
    logic                          mem_empty;
    logic                          almost_full;
    logic                          almost_empty;
    logic [ptr_width(DEPTH)-1:0]   fill_count;
    logic                          overflow;
    logic                          underflow;

    modport master (
        output write_en, read_en, data_in,
        input  out, mem_full, mem_empty, almost_full, almost_empty,
               fill_count, overflow, underflow
    );

    modport slave (
        input  write_en, read_en, data_in,
        output out, mem_full, mem_empty, almost_full, almost_empty,
               fill_count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram
// Simple dual-port storage, WIDTH x DEPTH.
//   clk   : write clock
//   we    : write enable, waddr/wdata written on the rising edge
//   raddr : read address, rdata follows it combinationally
// The array is never reset; the pointers decide what is valid.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock parametrised FIFO with fill count, threshold flags and
// overflow/underflow pulses.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high, clears pointers, flags and out
//   bus   : sync_fifo_param_if slave modport (see interface header)
// Build option: define SYNC_FIFO_FWFT_EN for first-word fall-through,
// where out shows the head entry directly instead of a registered
// latency-1 read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset,
    sync_fifo_param_if.slave  bus
);
    localparam int   AW     = addr_width(DEPTH);
    localparam int   PW     = ptr_width(DEPTH);
    localparam logic AF_RST = (AF_THRESH == 0);

    if (!params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_param: illegal WIDTH/DEPTH/threshold parameters");
    end

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] ram_rdata;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    // The count falls out of the pointer difference; the extra MSB keeps
    // DEPTH and 0 apart across rollover.
    always_comb begin
        wr_acc     = bus.write_en && !bus.mem_full;
        rd_acc     = bus.read_en && !bus.mem_empty;
        wr_ptr_nxt = wr_ptr + PW'(wr_acc);
        rd_ptr_nxt = rd_ptr + PW'(rd_acc);
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Pointers, count and flags all register from the same next-count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            bus.fill_count   <= '0;
            bus.mem_full     <= 1'b0;
            bus.mem_empty    <= 1'b1;
            bus.almost_full  <= AF_RST;
            bus.almost_empty <= 1'b1;
            bus.overflow     <= 1'b0;
            bus.underflow    <= 1'b0;
        end else begin
            wr_ptr           <= wr_ptr_nxt;
            rd_ptr           <= rd_ptr_nxt;
            bus.fill_count   <= count_nxt;
            bus.mem_full     <= (count_nxt == PW'(DEPTH));
            bus.mem_empty    <= (count_nxt == '0);
            bus.almost_full  <= (count_nxt >= PW'(AF_THRESH));
            bus.almost_empty <= (count_nxt <= PW'(AE_THRESH));
            bus.overflow     <= bus.write_en && bus.mem_full;
            bus.underflow    <= bus.read_en && bus.mem_empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is always on out; meaningless while empty.
    assign bus.out = ram_rdata;
`else
    // Registered read: the head word is captured on an accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out <= '0;
        end else if (rd_acc) begin
            bus.out <= ram_rdata;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AF = D - 2;
    localparam int AE = 2;
`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sync_fifo_param #(
        .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural reference: a plain queue plus the last read word.
    logic [W-1:0] q[$];
    logic [W-1:0] m_out = '0;
    bit           m_ov  = 1'b0;
    bit           m_un  = 1'b0;

    typedef struct {
        bit           we;
        bit           re;
        logic [W-1:0] din;
        int           cnt;
        bit           full;
        bit           empty;
        bit           af;
        bit           ae;
        bit           ov;
        bit           un;
        logic [W-1:0] dout;
        bit           chk_out;
    } vec_t;
    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit w, input bit r, input logic [W-1:0] d, input bit rs);
        bit full, empty;
        if (rs) begin
            q.delete();
            m_out = '0;
            m_ov  = 1'b0;
            m_un  = 1'b0;
        end else begin
            full  = (q.size() == D);
            empty = (q.size() == 0);
            m_ov  = w && full;
            m_un  = r && empty;
            if (r && !empty) m_out = q.pop_front();
            if (w && !full) q.push_back(d);
        end
    endtask

    task automatic cycle(input bit w, input bit r, input logic [W-1:0] d, input bit rs);
        bus.write_en = w;
        bus.read_en  = r;
        bus.data_in  = d;
        reset        = rs;
        @(posedge clk);
        model_step(w, r, d, rs);
        #1;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(bus.fill_count), 32'(n));
        chk({tag, ".full"},  32'(bus.mem_full), 32'(n == D));
        chk({tag, ".empty"}, 32'(bus.mem_empty), 32'(n == 0));
        chk({tag, ".af"},    32'(bus.almost_full), 32'(n >= AF));
        chk({tag, ".ae"},    32'(bus.almost_empty), 32'(n <= AE));
        chk({tag, ".ov"},    32'(bus.overflow), 32'(m_ov));
        chk({tag, ".un"},    32'(bus.underflow), 32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
        if (n > 0) chk({tag, ".out"}, 32'(bus.out), 32'(q[0]));
`else
        chk({tag, ".out"}, 32'(bus.out), 32'(m_out));
`endif
    endtask

    task automatic add_vec(input bit we, input bit re, input logic [W-1:0] din,
                           input int cnt, input bit ov, input bit un,
                           input logic [W-1:0] dout, input bit chk_out);
        vec_t v;
        v.we = we; v.re = re; v.din = din; v.cnt = cnt;
        v.full = (cnt == D); v.empty = (cnt == 0);
        v.af = (cnt >= AF); v.ae = (cnt <= AE);
        v.ov = ov; v.un = un; v.dout = dout; v.chk_out = chk_out;
        tab.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fill / overflow / drain / underflow sequence for DEPTH=8.
        for (int k = 1; k <= D; k++)
            add_vec(1, 0, W'(k), k, 0, 0, FWFT ? 8'h01 : 8'h00, 1);
        add_vec(1, 0, 8'hFF, D, 1, 0, FWFT ? 8'h01 : 8'h00, 1);
        for (int r = 1; r <= D; r++)
            add_vec(0, 1, 8'h00, D - r, 0, 0, FWFT ? W'(r + 1) : W'(r), !FWFT || (r != D));
        add_vec(0, 1, 8'h00, 0, 0, 1, 8'h08, !FWFT);
        add_vec(0, 0, 8'h00, 0, 0, 0, 8'h08, !FWFT);

        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.data_in  = '0;

        // Reset then idle.
        cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 0);
        chk("rst.count", 32'(bus.fill_count), 0);
        chk("rst.empty", 32'(bus.mem_empty), 1);
        chk("rst.full",  32'(bus.mem_full), 0);
        chk("rst.ae",    32'(bus.almost_empty), 1);
        chk("rst.af",    32'(bus.almost_full), 0);
        chk("rst.ov",    32'(bus.overflow), 0);
        chk("rst.un",    32'(bus.underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst.out",   32'(bus.out), 0);
`endif

        // Table-driven vectors.
        foreach (tab[i]) begin
            cycle(tab[i].we, tab[i].re, tab[i].din, 0);
            chk($sformatf("v%0d.count", i), 32'(bus.fill_count), 32'(tab[i].cnt));
            chk($sformatf("v%0d.full", i),  32'(bus.mem_full), 32'(tab[i].full));
            chk($sformatf("v%0d.empty", i), 32'(bus.mem_empty), 32'(tab[i].empty));
            chk($sformatf("v%0d.af", i),    32'(bus.almost_full), 32'(tab[i].af));
            chk($sformatf("v%0d.ae", i),    32'(bus.almost_empty), 32'(tab[i].ae));
            chk($sformatf("v%0d.ov", i),    32'(bus.overflow), 32'(tab[i].ov));
            chk($sformatf("v%0d.un", i),    32'(bus.underflow), 32'(tab[i].un));
            if (tab[i].chk_out)
                chk($sformatf("v%0d.out", i), 32'(bus.out), 32'(tab[i].dout));
        end

        // Steady simultaneous traffic at count 4 across pointer wrap.
        for (int k = 0; k < 4; k++) cycle(1, 0, W'(8'h40 + k), 0);
        for (int k = 0; k < 20; k++) begin
            cycle(1, 1, W'(8'h44 + k), 0);
            chk("pair.count4", 32'(bus.fill_count), 4);
            check_model("pair");
        end

        // Full with simultaneous write and read: read wins, write rejected.
        for (int k = 0; k < 4; k++) cycle(1, 0, W'(8'h60 + k), 0);
        chk("full.flag", 32'(bus.mem_full), 1);
        cycle(1, 1, 8'hEE, 0);
        chk("fullpair.ov",    32'(bus.overflow), 1);
        chk("fullpair.count", 32'(bus.fill_count), D - 1);
        check_model("fullpair");
        cycle(0, 0, 8'h00, 0);
        chk("fullpair.ovend", 32'(bus.overflow), 0);

        // Empty with simultaneous write and read: write wins, underflow.
        while (q.size() > 0) cycle(0, 1, 8'h00, 0);
        cycle(1, 1, 8'h5A, 0);
        chk("emptypair.un",    32'(bus.underflow), 1);
        chk("emptypair.count", 32'(bus.fill_count), 1);
        check_model("emptypair");

        // Reset mid-stream discards contents.
        cycle(1, 0, 8'h11, 0);
        cycle(1, 0, 8'h22, 0);
        cycle(1, 0, 8'h33, 0);
        cycle(1, 1, 8'h77, 1);
        chk("midrst.count", 32'(bus.fill_count), 0);
        chk("midrst.empty", 32'(bus.mem_empty), 1);
        cycle(1, 0, 8'hA5, 0);
        chk("midrst.count1", 32'(bus.fill_count), 1);
`ifdef SYNC_FIFO_FWFT_EN
        chk("midrst.fwft_out", 32'(bus.out), 32'h A5);
`endif
        cycle(0, 1, 8'h00, 0);
        chk("midrst.count0", 32'(bus.fill_count), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("midrst.out", 32'(bus.out), 32'h A5);
`endif

`ifdef SYNC_FIFO_FWFT_EN
        // Fall-through: word appears without read_en.
        cycle(1, 0, 8'h3C, 0);
        chk("fwft.out", 32'(bus.out), 32'h3C);
        chk("fwft.empty", 32'(bus.mem_empty), 0);
        cycle(0, 0, 8'h00, 0);
        chk("fwft.hold", 32'(bus.out), 32'h3C);
        cycle(1, 0, 8'h4D, 0);
        cycle(0, 1, 8'h00, 0);
        chk("fwft.next", 32'(bus.out), 32'h4D);
        cycle(0, 1, 8'h00, 0);
        chk("fwft.drained", 32'(bus.mem_empty), 1);
`endif

        // Randomised traffic against the queue model.
        for (int k = 0; k < 900; k++) begin
            int pw, pr;
            bit w, r, rs;
            pw = (k < 300) ? 80 : (k < 600) ? 20 : 50;
            pr = (k < 300) ? 25 : (k < 600) ? 80 : 50;
            w  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < pr);
            rs = ($urandom_range(0, 79) == 0);
            cycle(w, r, W'($urandom), rs);
            check_model($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
